// File: rtl/rx_pkg.sv
// rx_pkg: constants shared by the UART byte assembler, the key-select stage
// and the benches. Block geometry plus the key marker pattern.
package rx_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;
    localparam int CNT_W       = $clog2(BLOCK_BYTES);

    localparam logic [BLOCK_W-1:0] KEY_MARKER = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

    typedef logic [CNT_W-1:0] byte_cnt_t;

    // True when a partial block holds all but its final byte.
    function automatic logic is_last_slot(input byte_cnt_t cnt);
        return cnt == byte_cnt_t'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// rx_idle_timer: counts idle cycles while a partial block is open.
// expire is a one-cycle pulse on the cycle in which the counter would reach
// TIMEOUT_CYCLES-1 without a new byte; the owner registers it, so the visible
// drop lands TIMEOUT_CYCLES cycles after the last accepted byte.
// Only instantiated when RX_SHIFT_TIMEOUT_EN is defined.
module rx_idle_timer
    import rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,   // asynchronous, active low
    input  logic run,     // a partial block is open
    input  logic clear,   // a byte is accepted this cycle
    output logic expire
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT_CYCLES - 2);

    logic [TW-1:0] idle_cnt;

    // A byte in the same cycle always wins over the timeout.
    assign expire = run && !clear && (idle_cnt == LAST_IDLE);

    // Idle counter: held at zero when no block is open, on every byte and on expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (!run || clear || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/rx_shift.sv
// rx_shift: packs UART bytes MSB-first into 128-bit blocks. Sixteen accepted
// bytes produce one registered block update with a single-cycle write_en.
// Optional inter-byte idle timeout (macro RX_SHIFT_TIMEOUT_EN) discards a
// partial block and pulses drop_err; without the macro partial blocks persist.
module rx_shift
    import rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               reset,     // asynchronous, active low
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [BLOCK_W-1:0] block,
    output logic               write_en,
    output logic [3:0]         byte_cnt,
    output logic               drop_err
);

    // Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is
    // no ready; every rx_valid cycle is accepted unconditionally, one byte per
    // clock at most. write_en and drop_err are one-cycle strobes with no ready.

    logic [BLOCK_W-1:0] shreg;
    logic [BLOCK_W-1:0] shreg_next;
    logic               last_byte;
    logic               expire;

    assign shreg_next = {shreg[BLOCK_W-9:0], rx_data};
    assign last_byte  = rx_valid && is_last_slot(byte_cnt);

`ifdef RX_SHIFT_TIMEOUT_EN
    rx_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (byte_cnt != 4'd0),
        .clear  (rx_valid),
        .expire (expire)
    );

    // Drop strobe: one cycle after the timer decides to discard the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else begin
            drop_err <= expire;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES >= 2);
    assign expire         = 1'b0;
    assign drop_err       = 1'b0;
`endif

    // Shift register: stale bytes after a drop are pushed out by new ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (rx_valid) begin
            shreg <= shreg_next;
        end
    end

    // Byte counter: a byte wins over the timeout; the 16th byte wraps to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 4'd0;
        end else if (rx_valid) begin
            byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
        end else if (expire) begin
            byte_cnt <= 4'd0;
        end
    end

    // Block output and write strobe: registered on the edge sampling byte 16.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block    <= '0;
            write_en <= 1'b0;
        end else begin
            write_en <= last_byte;
            if (last_byte) begin
                block <= shreg_next;
            end
        end
    end

endmodule

// File: tb/tb_rx_shift.sv
// tb_rx_shift: table vectors, directed corner sequences and random traffic
// against a queue-based reference model of the byte assembler.
module tb_rx_shift;
    import rx_pkg::*;

    localparam int T = 50;
`ifdef RX_SHIFT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] block;
    logic         write_en;
    logic [3:0]   byte_cnt;
    logic         drop_err;

    rx_shift #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .block    (block),
        .write_en (write_en),
        .byte_cnt (byte_cnt),
        .drop_err (drop_err)
    );

    // clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0]   part_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] m_block = '0;
    logic         m_we = 1'b0;
    logic         m_drop = 1'b0;
    int           m_idle = 0;
    int           we_seen = 0;

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         exp_we;
        logic [3:0]   exp_cnt;
        logic [127:0] exp_blk;
    } vec_t;
    vec_t vecs[32];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a block is the 16 most recent bytes of an unbroken partial run.
    task automatic model_step(input logic v, input logic [7:0] d);
        m_we   = 1'b0;
        m_drop = 1'b0;
        if (v) begin
            part_q.push_back(d);
            m_idle = 0;
            if (part_q.size() == BLOCK_BYTES) begin
                m_block = '0;
                for (int i = 0; i < BLOCK_BYTES; i++)
                    m_block = m_block | (128'(part_q[i]) << (8 * (BLOCK_BYTES - 1 - i)));
                exp_q.push_back(m_block);
                part_q.delete();
                m_we = 1'b1;
            end
        end else if (part_q.size() != 0) begin
            m_idle++;
            if (TO_EN && m_idle == T - 1) begin
                part_q.delete();
                m_drop = 1'b1;
                m_idle = 0;
            end
        end
    endtask

    // driver: one clock with the given byte strobe, then compare everything
    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = v ? d : 8'($urandom);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        model_step(v, d);
        chk("write_en", 128'(write_en), 128'(m_we));
        chk("byte_cnt", 128'(byte_cnt), 128'(part_q.size()));
        chk("drop_err", 128'(drop_err), 128'(m_drop));
        chk("block", block, m_block);
        if (write_en) begin
            we_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write_en=1 expected no block");
            end else begin
                chk("sb_block", block, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_block", block, 128'd0);
        chk("rst_we", 128'(write_en), 128'd0);
        chk("rst_cnt", 128'(byte_cnt), 128'd0);
        chk("rst_drop", 128'(drop_err), 128'd0);
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_hold_block", block, 128'd0);
        chk("rst_hold_cnt", 128'(byte_cnt), 128'd0);
        chk("rst_hold_we", 128'(write_en), 128'd0);
        reset = 1'b1;
        part_q.delete();
        exp_q.delete();
        m_block = '0;
        m_we    = 1'b0;
        m_drop  = 1'b0;
        m_idle  = 0;
    endtask

    // idle until drop_err, returning cycles since the last byte's strobe cycle
    task automatic wait_drop(input string name, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 1;
        while (!got && cyc < 3 * T) begin
            step(1'b0, 8'h00);
            cyc++;
            if (drop_err) got = 1'b1;
        end
        checks++;
        if (!got || cyc != T) begin
            errors++;
            $display("FAIL %s: got drop after %0d cycles (seen=%0d) expected %0d", name, cyc, got, T);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int we_base;
        logic [7:0] mk[4];
        mk[0] = 8'hDE; mk[1] = 8'hAD; mk[2] = 8'hBE; mk[3] = 8'hEF;

        for (int i = 0; i < 32; i++) begin
            vecs[i].v       = 1'b1;
            vecs[i].d       = (i < 16) ? mk[i % 4] : 8'(8'h10 + i - 16);
            vecs[i].exp_we  = (i == 15) || (i == 31);
            vecs[i].exp_cnt = 4'((i + 1) % 16);
            vecs[i].exp_blk = (i < 15) ? 128'd0 :
                              (i < 31) ? KEY_MARKER : 128'h101112131415161718191A1B1C1D1E1F;
        end

        // reset
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk);
        #1;
        do_reset(2);

        // 1: slow bytes 00..0F, one every 10 cycles
        we_base = we_seen;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i));
            if (i == 15) chk("t1_we_latency", 128'(write_en), 128'd1);
            repeat (9) step(1'b0, 8'h00);
        end
        chk("t1_block", block, 128'h000102030405060708090A0B0C0D0E0F);
        chk("t1_we_count", 128'(we_seen - we_base), 128'd1);

        // 2: marker then key, back to back (table)
        do_reset(1);
        for (int i = 0; i < 32; i++) begin
            step(vecs[i].v, vecs[i].d);
            chk("t2_we", 128'(write_en), 128'(vecs[i].exp_we));
            chk("t2_cnt", 128'(byte_cnt), 128'(vecs[i].exp_cnt));
            chk("t2_block", block, vecs[i].exp_blk);
        end

`ifdef RX_SHIFT_TIMEOUT_EN
        // 3: timeout drop, then a clean block
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i));
        wait_drop("t3_drop_time", cyc);
        chk("t3_cnt_after_drop", 128'(byte_cnt), 128'd0);
        repeat (60 - cyc) step(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'hA0 + i));
        chk("t3_we", 128'(write_en), 128'd1);
        chk("t3_block", block, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

        // 4: byte on the cycle the timeout would fire
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i));
        repeat (T - 2) step(1'b0, 8'h00);
        step(1'b1, 8'h43);
        chk("t4_no_drop", 128'(drop_err), 128'd0);
        chk("t4_cnt", 128'(byte_cnt), 128'd4);
        wait_drop("t4_restart_drop", cyc);
`else
        // 6: long gap with the timeout compiled out
        we_base = we_seen;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i));
        repeat (10 * T) step(1'b0, 8'h00);
        chk("t6_cnt_kept", 128'(byte_cnt), 128'd5);
        for (int i = 5; i < 16; i++) step(1'b1, 8'(8'h50 + i));
        chk("t6_block", block, 128'h505152535455565758595A5B5C5D5E5F);
        chk("t6_we_count", 128'(we_seen - we_base), 128'd1);
`endif

        // 5: reset in the middle of a block
        we_base = we_seen;
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i));
        do_reset(3);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i));
        chk("t5_block", block, 128'h202122232425262728292A2B2C2D2E2F);
        chk("t5_we_count", 128'(we_seen - we_base), 128'd1);

        // random traffic with occasional long gaps
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                step(1'b1, 8'($urandom));
            end else begin
                repeat ($urandom_range(1, (r == 9) ? 70 : 8)) step(1'b0, 8'h00);
            end
            if (n == 700) do_reset($urandom_range(1, 4));
        end

        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_shift.md
# rx_shift

Assembles the byte stream from the UART receiver into 128-bit blocks for the key/plaintext selector. Sixteen accepted bytes are packed MSB-first into one block, presented on `block` with a single-cycle `write_en` strobe. Sits between the UART RX byte decoder and the key-select stage. An optional inter-byte idle timeout discards partial blocks so the host can resynchronise after a dropped byte.

## Interface
- `TIMEOUT_CYCLES`, default 2000000: idle clock cycles allowed between bytes of a partial block before it is discarded. Only used when the timeout is compiled in; must be ≥ 2.
- `clk` input, 1: system clock, rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `rx_data` input, 8: received byte; valid only while `rx_valid`=1.
- `rx_valid` input, 1: one-cycle strobe per received byte. No backpressure: the block accepts a byte every cycle if needed.
- `block` output, 128: last completed block. Held stable until the next completion.
- `write_en` output, 1: one-cycle pulse when `block` is updated.
- `byte_cnt` output, 4: bytes held in the current partial block, 0–15.
- `drop_err` output, 1: one-cycle pulse when the timeout discards a partial block.

## Operation
- **Reset values:** `reset`=0 forces the following immediately, independent of `clk`:
  - `block`, the internal shift register, `byte_cnt` and the idle counter all to 0.
  - `write_en` and `drop_err` to 0.
- **Byte order:** the first byte of a block lands in `block[127:120]`. The 16th byte lands in `block[7:0]`.
- **Accepting a byte:** each `rx_valid`=1 cycle shifts the internal register left 8 bits, inserts `rx_data`, and increments `byte_cnt`.
- **Completing a block:** on the 16th byte (`byte_cnt`=15 and `rx_valid`=1):
  - the full 128-bit value, including the current byte, is written to `block`;
  - `write_en` goes to 1;
  - `byte_cnt` wraps to 0.
- **Block contents:** the block has no knowledge of marker values; 0xDEADBEEF… blocks pass through unchanged.
- **Idle counter:** runs only while `byte_cnt` is nonzero. It clears on every accepted byte and on completion.
- **Timeout:**
  - When the idle counter reaches `TIMEOUT_CYCLES`-1 with no `rx_valid`, the partial block is discarded: `byte_cnt` goes to 0 and `drop_err` pulses.
  - The shift register is not cleared; stale bytes are shifted out by the next 16 bytes.
- **Simultaneous events:**
  - A byte arriving in the cycle the timeout would fire wins. The byte is accepted, and there is no drop.
  - A byte arriving in the cycle `write_en` is high is byte 0 of the next block.
- **Reset during a partial block:** the partial block is lost and no strobe is emitted.

## Timing
- **Latency:** `write_en` and the new `block` are visible in the cycle after the edge that samples the 16th `rx_valid`. This is a one-cycle registered latency.
- **Pulse width:** `write_en` and `drop_err` are high for exactly one cycle and are never high together.
- **Throughput:** up to one byte per cycle. Back-to-back 16-byte blocks give one `write_en` every 16 cycles.
- **`byte_cnt` update:** registered; it updates on the same edge as the byte it counts.
- **Timeout point:** `drop_err` is high `TIMEOUT_CYCLES` cycles after the last accepted byte of a partial block.

## Configuration
- **Macro:** `RX_SHIFT_TIMEOUT_EN`.
- **Defined:** the idle counter and `drop_err` logic are built as described under Operation.
- **Undefined:**
  - the idle counter is not built;
  - `drop_err` is tied to 0;
  - partial blocks persist indefinitely until completed or reset;
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- **Shared package `rx_pkg`:**
  - `BLOCK_BYTES`=16 and `BLOCK_W`=128.
  - `KEY_MARKER`=128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, shared with the key-select stage and benches.
- **Sub-module `rx_idle_timer`:**
  - Inputs: `clk`, `reset`, `run`, `clear`.
  - Output: one-cycle `expire`.
  - Width: `$clog2(TIMEOUT_CYCLES)`.
  - Instantiated only under `RX_SHIFT_TIMEOUT_EN`.

## Test plan
1. **Basic block:**
   - Stimulus: bytes 0x00..0x0F with one `rx_valid` every 10 cycles.
   - Response: `block`=0x000102030405060708090A0B0C0D0E0F and a single `write_en` pulse one cycle after byte 0x0F is sampled.
2. **Back-to-back marker then key:**
   - Stimulus: 16× (DE AD BE EF pattern) followed immediately by bytes 0x10..0x1F, all with `rx_valid` every cycle.
   - Response: two `write_en` pulses 16 cycles apart. `block`=`KEY_MARKER`, then 0x101112…1F.
3. **Timeout drop (macro on, `TIMEOUT_CYCLES`=50):**
   - Stimulus: 5 bytes, a 60-cycle gap, then bytes 0xA0..0xAF.
   - Response:
     - `drop_err` pulses 50 cycles after the 5th byte;
     - `byte_cnt` is 0 after the drop;
     - the next `write_en` carries 0xA0A1…AF.
4. **Byte vs. timeout race:**
   - Stimulus: a byte arrives exactly on the cycle the timeout would fire.
   - Response: no `drop_err`, and `byte_cnt` increments.
5. **Reset mid-block:**
   - Stimulus: 7 bytes, `reset` low for 3 cycles, then 16 bytes 0x20..0x2F.
   - Response:
     - all outputs go to 0 while `reset` is low;
     - no `write_en` from the partial block;
     - `block`=0x2021…2F after the 16 bytes.
6. **Macro off:**
   - Stimulus: 5 bytes, a gap of 10× `TIMEOUT_CYCLES`, then 11 bytes.
   - Response: `drop_err` stays 0, and one `write_en` fires with all 16 bytes in order.
